// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock with a registered borrow.
// Start/busy/done handshake; results hold until the next accepted start.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0]  count;
  logic           borrow;
  logic           a, b, d, c_nxt;

  always_comb begin
    a     = a_sr[0];
    b     = b_sr[0];
    d     = a ^ b ^ borrow;
    c_nxt = (~a & b) | (~(a ^ b) & borrow);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      count      <= '0;
      borrow     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      difference <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr       <= minuend;
          b_sr       <= subtrahend;
          borrow     <= 1'b0;
          count      <= '0;
          difference <= '0;
          borrow_out <= 1'b0;
          overflow   <= 1'b0;
          busy       <= 1'b1;
          state      <= SHIFT;
        end
        SHIFT: begin
          difference <= {d, difference[WIDTH-1:1]};
          a_sr       <= a_sr >> 1;
          b_sr       <= b_sr >> 1;
          borrow     <= c_nxt;
          count      <= count + 1'b1;
          // On the MSB step a/b are the operand sign bits and d is the result sign.
          if (count == CW'(WIDTH-1)) begin
            state      <= DONE;
            done       <= 1'b1;
            borrow_out <= c_nxt;
            overflow   <= (a ^ b) & (d ^ a);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed + random ops on an 8-bit instance,
// exhaustive sweep on a 4-bit instance, against an arithmetic reference.
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst;
  logic       st8, st4;
  logic [7:0] mn8, sb8;
  logic [3:0] mn4, sb4;
  logic       busy8, done8, bo8, ov8;
  logic       busy4, done4, bo4, ov4;
  logic [7:0] diff8;
  logic [3:0] diff4;
  logic       sel4;
  int         total = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .minuend(mn8), .subtrahend(sb8),
    .busy(busy8), .done(done8), .difference(diff8), .borrow_out(bo8), .overflow(ov8));

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .minuend(mn4), .subtrahend(sb4),
    .busy(busy4), .done(done4), .difference(diff4), .borrow_out(bo4), .overflow(ov4));

  wire       busy_s = sel4 ? busy4 : busy8;
  wire       done_s = sel4 ? done4 : done8;
  wire [7:0] diff_s = sel4 ? {4'b0, diff4} : diff8;
  wire       bo_s   = sel4 ? bo4 : bo8;
  wire       ov_s   = sel4 ? ov4 : ov8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular / signed arithmetic on w-bit operands.
  function automatic void ref_sub(input int w, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] d, output bit br, output bit ov);
    int mask = (1 << w) - 1;
    int half = 1 << (w - 1);
    int ua = int'(a) & mask;
    int ub = int'(b) & mask;
    int sa = (ua >= half) ? ua - (1 << w) : ua;
    int sb = (ub >= half) ? ub - (1 << w) : ub;
    int s  = sa - sb;
    d  = 8'((ua - ub) & mask);
    br = ua < ub;
    ov = (s > half - 1) || (s < -half);
  endfunction

  task automatic run(input bit w4, input logic [7:0] a, input logic [7:0] b, input string tag);
    int w = w4 ? 4 : 8;
    int edges = 0;
    int bsy = 0;
    logic [7:0] ed;
    bit eb, eo;
    ref_sub(w, a, b, ed, eb, eo);
    sel4 = w4;
    @(negedge clk);
    if (w4) begin mn4 = a[3:0]; sb4 = b[3:0]; st4 = 1'b1; end
    else    begin mn8 = a;      sb8 = b;      st8 = 1'b1; end
    @(posedge clk); #1;
    st4 = 1'b0; st8 = 1'b0;
    mn8 = 8'($urandom); sb8 = 8'($urandom); mn4 = 4'($urandom); sb4 = 4'($urandom);
    while (edges < 40) begin
      @(negedge clk);
      if (busy_s) bsy++;
      if (done_s) break;
      @(posedge clk);
      edges++;
    end
    chk({tag, " latency"}, edges + 1, w + 1);
    chk({tag, " busy_cycles"}, bsy, w + 1);
    chk({tag, " diff"}, diff_s, ed);
    chk({tag, " borrow"}, bo_s, eb);
    chk({tag, " ovf"}, ov_s, eo);
    @(negedge clk);
    chk({tag, " done_pulse"}, {busy_s, done_s}, 2'b00);
    chk({tag, " diff_hold"}, diff_s, ed);
  endtask

  initial begin
    logic [7:0] ea, eb8, ed;
    bit eb, eo;
    int dn;
    rst = 1'b1; st8 = 0; st4 = 0; mn8 = 0; sb8 = 0; mn4 = 0; sb4 = 0; sel4 = 0;
    repeat (2) @(negedge clk);
    chk("reset_outs8", {busy8, done8, diff8, bo8, ov8}, '0);
    chk("reset_outs4", {busy4, done4, diff4, bo4, ov4}, '0);
    rst = 1'b0;

    run(0, 8'd5,   8'd3,   "t1_5m3");
    run(0, 8'd3,   8'd5,   "t2_3m5");
    run(0, 8'h80,  8'h01,  "t3_80m01");
    run(0, 8'h00,  8'h00,  "t3_0m0");
    run(0, 8'h00,  8'h01,  "wrap_0m1");
    run(0, 8'h7F,  8'hFF,  "t_7Fm_FF");

    // Start held high with operands changing every cycle.
    sel4 = 0;
    @(negedge clk);
    st8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ea = 8'($urandom); eb8 = 8'($urandom);
      mn8 = ea; sb8 = eb8;
      ref_sub(8, ea, eb8, ed, eb, eo);
      @(posedge clk);
      for (int i = 1; i <= 9; i++) begin
        @(negedge clk);
        if (i == 9) begin
          chk("t4_done", done8, 1'b1);
          chk("t4_diff", diff8, ed);
          chk("t4_flags", {bo8, ov8}, {eb, eo});
        end else if (done8) chk("t4_early_done", done8, 1'b0);
        mn8 = 8'($urandom); sb8 = 8'($urandom);
        if (i < 9) @(posedge clk);
      end
      @(posedge clk);
      @(negedge clk);
    end
    st8 = 1'b0;
    repeat (12) @(negedge clk);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    mn8 = 8'hAA; sb8 = 8'h55; st8 = 1'b1;
    @(posedge clk); #1 st8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("t5_rst_outs", {busy8, done8, diff8, bo8, ov8}, '0);
    @(negedge clk) rst = 1'b0;
    dn = 0;
    repeat (12) begin @(negedge clk); if (done8 || busy8) dn++; end
    chk("t5_no_done", dn, 0);
    run(0, 8'hAA, 8'h55, "t5_AAm55");

    for (int k = 0; k < 20; k++) run(0, 8'($urandom), 8'($urandom), "rand8");

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run(1, 8'(a), 8'(b), "exh4");

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
